joybus_rx_decoder: RTL and testbench
====================================

// Module: joybus_rx_decoder
// PURPOSE
//  Consumes the debounced Joybus line and decodes pulse widths into bits, bytes and frames.
//  Joybus bit cell: '0' = long low + short high; '1' = short low + long high.
//  Frames end with a single '1' stop bit followed by idle-high.
//  Feeds the controller-report parser with bytes plus an end-of-frame status.
// PARAMETERS
//  BIT_THRESH    96   low-phase cycles; low < BIT_THRESH -> '1', else '0' (1us=48 clk @48MHz)
//  LOW_MAX       240  low-phase cycles above which the pulse is illegal (line stuck low)
//  IDLE_TIMEOUT  240  consecutive high cycles after a low pulse that end a frame
//  MAX_BYTES     8    bytes accepted per frame; more flags an overflow error
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  enable       in   1   decoder run; low = synchronous flush to IDLE
//  line         in   1   debounced Joybus level (1 = released/high)
//  byte_data    out  8   last completed byte, MSB received first
//  byte_valid   out  1   one-cycle strobe, byte_data valid
//  byte_index   out  4   index (0..MAX_BYTES-1) of byte on byte_data
//  frame_done   out  1   one-cycle strobe at end of frame
//  frame_ok     out  1   valid with frame_done: stop bit correct, no error
//  frame_bytes  out  4   valid with frame_done: bytes received (saturates at MAX_BYTES)
//  err_stuck    out  1   one-cycle strobe when low phase reaches LOW_MAX
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE, all counters/shift reg 0, every output 0.
//  - line registered once (line_q); fall = line_q&~line, rise = ~line_q&line.
//  - IDLE: wait for fall; on fall -> LOW, low_cnt=1.
//  - LOW: low_cnt++ each cycle line=0, saturating at LOW_MAX.
//    - low_cnt==LOW_MAX -> err_stuck 1 cycle, frame error latched, -> WAIT_HIGH.
//    - On rise: bit = (low_cnt<BIT_THRESH); shift into shreg, bit_cnt++; -> HIGH, high_cnt=1.
//    - On 8th bit: byte_data, byte_index, byte_valid=1 registered on that edge.
//      bit_cnt->0, byte_cnt++ (saturating at MAX_BYTES).
//    - A 9th byte sets overflow error; its byte_valid is suppressed.
//  - HIGH: high_cnt++ while line=1.
//    - fall before IDLE_TIMEOUT -> LOW, low_cnt=1, no frame end.
//    - high_cnt==IDLE_TIMEOUT -> frame_done=1 for 1 cycle; frame_bytes=byte_cnt.
//      frame_ok=1 iff bit_cnt==1 && last bit=='1' && byte_cnt>=1 && no error latched.
//      Then clear counters/error -> IDLE.
//  - WAIT_HIGH: ignore line until high IDLE_TIMEOUT cycles.
//    Then frame_done with frame_ok=0 and current byte_cnt -> IDLE.
//  - Frame begun mid-pulse (first edge a rise): ignored; IDLE needs a fall.
//  - enable=0: next edge state IDLE, counters/error cleared, no strobes.
//    byte_data holds value; enable re-high waits for fresh fall.
//  - Strobes never overlap: byte_valid on a rise edge, frame_done only in HIGH/WAIT_HIGH timeout.
//  - Counters sized $clog2(max(LOW_MAX,IDLE_TIMEOUT)+1); no wrap, all saturate.
// TESTING
//  - Reset mid-frame (after 5 bits): rst_n low 1 cycle -> outputs 0.
//    Next full frame decodes cleanly from byte 0.
//  - Byte 0x41 + stop (low 48/144 clk) + 240 high:
//    byte_valid once, data=0x41, idx=0; frame_done, ok=1, bytes=1.
//  - Thresholds: low 95 -> bit '1'; low 96 -> bit '0'.
//    8-bit 0x80 vs 0x00 patterns check the boundary.
//  - Line held low 300 clk: err_stuck at cycle 240.
//    After 240 high: frame_done, ok=0, bytes=0.
//  - 9 bytes 0xFF + stop: 8 byte_valid (idx 0..7), 9th suppressed.
//    frame_done ok=0, bytes=8.
//  - Missing stop (8 bits then idle): frame_done ok=0, bytes=1.
//    enable dropped mid-byte: no strobes; next frame decodes ok.

Source files
------------

// File: rtl/joybus_rx_decoder.sv
// Joybus receive decoder.
// Measures the low and high phases of the debounced line and turns them into
// bits, bytes and frames. Each '1' or '0' bit is classified from the length
// of its low phase. A frame ends after a long idle-high period, and the frame
// status tells the parser whether the frame was well formed.
module joybus_rx_decoder #(
  parameter int unsigned BIT_THRESH   = 96,
  parameter int unsigned LOW_MAX      = 240,
  parameter int unsigned IDLE_TIMEOUT = 240,
  parameter int unsigned MAX_BYTES    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       line,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [3:0] byte_index,
  output logic       frame_done,
  output logic       frame_ok,
  output logic [3:0] frame_bytes,
  output logic       err_stuck
);

  localparam int unsigned CMAX = (LOW_MAX > IDLE_TIMEOUT) ? LOW_MAX : IDLE_TIMEOUT;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] TH_C   = CW'(BIT_THRESH);
  localparam logic [CW-1:0] LOW_C  = CW'(LOW_MAX);
  localparam logic [CW-1:0] IDLE_C = CW'(IDLE_TIMEOUT);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [3:0]    MAX_C  = 4'(MAX_BYTES);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, WAIT_HIGH} state_t;

  state_t        state;
  logic          line_q;
  logic [CW-1:0] low_cnt;
  logic [CW-1:0] high_cnt;
  logic [2:0]    bit_cnt;
  logic [3:0]    byte_cnt;
  logic [7:0]    shreg;
  logic          err;

  logic          fall;
  logic          rise;
  logic          bit_now;
  logic [7:0]    next_shreg;
  logic          ok_now;

  // Edge detection, classification of the bit just ended, and frame status
  always_comb begin
    fall       = line_q & ~line;
    rise       = ~line_q & line;
    bit_now    = (low_cnt < TH_C);
    next_shreg = {shreg[6:0], bit_now};
    ok_now     = (bit_cnt == 3'd1) && shreg[0] && (byte_cnt != 4'd0) && !err;
  end

  // Decoder FSM with registered outputs; strobes default low every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      line_q      <= 1'b0;
      low_cnt     <= '0;
      high_cnt    <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      shreg       <= '0;
      err         <= 1'b0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      byte_index  <= '0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      frame_bytes <= '0;
      err_stuck   <= 1'b0;
    end else begin
      line_q     <= line;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      err_stuck  <= 1'b0;
      if (!enable) begin
        state    <= IDLE;
        low_cnt  <= '0;
        high_cnt <= '0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        shreg    <= '0;
        err      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (fall) begin
              state   <= LOW;
              low_cnt <= ONE_C;
            end
          end
          LOW: begin
            if (rise) begin
              shreg <= next_shreg;
              if (bit_cnt == 3'd7) begin
                bit_cnt <= '0;
                // bytes beyond the limit are dropped and poison the frame
                if (byte_cnt < MAX_C) begin
                  byte_data  <= next_shreg;
                  byte_index <= byte_cnt;
                  byte_valid <= 1'b1;
                  byte_cnt   <= byte_cnt + 4'd1;
                end else begin
                  err <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
              state    <= HIGH;
              high_cnt <= ONE_C;
            end else if (low_cnt >= LOW_C - ONE_C) begin
              low_cnt   <= LOW_C;
              err_stuck <= 1'b1;
              err       <= 1'b1;
              high_cnt  <= '0;
              state     <= WAIT_HIGH;
            end else begin
              low_cnt <= low_cnt + ONE_C;
            end
          end
          HIGH: begin
            if (fall) begin
              state   <= LOW;
              low_cnt <= ONE_C;
            end else if (high_cnt >= IDLE_C - ONE_C) begin
              frame_done  <= 1'b1;
              frame_ok    <= ok_now;
              frame_bytes <= byte_cnt;
              bit_cnt     <= '0;
              byte_cnt    <= '0;
              shreg       <= '0;
              err         <= 1'b0;
              low_cnt     <= '0;
              high_cnt    <= '0;
              state       <= IDLE;
            end else begin
              high_cnt <= high_cnt + ONE_C;
            end
          end
          WAIT_HIGH: begin
            // only an unbroken high run of IDLE_TIMEOUT cycles releases the line
            if (!line) begin
              high_cnt <= '0;
            end else if (high_cnt >= IDLE_C - ONE_C) begin
              frame_done  <= 1'b1;
              frame_ok    <= 1'b0;
              frame_bytes <= byte_cnt;
              bit_cnt     <= '0;
              byte_cnt    <= '0;
              shreg       <= '0;
              err         <= 1'b0;
              low_cnt     <= '0;
              high_cnt    <= '0;
              state       <= IDLE;
            end else begin
              high_cnt <= high_cnt + ONE_C;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_joybus_rx_decoder.sv
// Directed bench for joybus_rx_decoder: drives bit cells on the line and
// checks bytes, frame status and stuck-line detection against hand values.
module tb_joybus_rx_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       line = 1'b1;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic [3:0] byte_index;
  logic       frame_done;
  logic       frame_ok;
  logic [3:0] frame_bytes;
  logic       err_stuck;

  joybus_rx_decoder #(
    .BIT_THRESH  (96),
    .LOW_MAX     (240),
    .IDLE_TIMEOUT(240),
    .MAX_BYTES   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .line       (line),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_index (byte_index),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .frame_bytes(frame_bytes),
    .err_stuck  (err_stuck)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int         cyc = 0;
  int         nbv = 0;
  int         nfd = 0;
  int         nst = 0;
  int         stuck_cyc = 0;
  logic [7:0] data_log [16];
  logic [3:0] idx_log  [16];
  logic       last_ok = 1'b0;
  logic [3:0] last_bytes = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record strobes on the falling edge, away from the sampling edge
  always @(negedge clk) begin
    if (byte_valid) begin
      data_log[nbv % 16] = byte_data;
      idx_log[nbv % 16]  = byte_index;
      nbv = nbv + 1;
    end
    if (frame_done) begin
      last_ok    = frame_ok;
      last_bytes = frame_bytes;
      nfd = nfd + 1;
    end
    if (err_stuck) begin
      stuck_cyc = cyc;
      nst = nst + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input int lo, input int hi);
    line = 1'b0;
    repeat (lo) @(negedge clk);
    line = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      if (b[i]) send_bit(48, 144);
      else      send_bit(144, 48);
    end
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_byte(b);
    send_bit(48, 0);
    idle(260);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"},  32'(byte_data),   32'h0);
    check({tag, "_bv"},    32'(byte_valid),  32'h0);
    check({tag, "_idx"},   32'(byte_index),  32'h0);
    check({tag, "_fd"},    32'(frame_done),  32'h0);
    check({tag, "_ok"},    32'(frame_ok),    32'h0);
    check({tag, "_fb"},    32'(frame_bytes), 32'h0);
    check({tag, "_stuck"}, 32'(err_stuck),   32'h0);
  endtask

  int b0, f0, s0, c0;

  initial begin
    // power-on reset
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    rst_n = 1'b1;
    idle(10);

    // single byte 0x41 with stop bit
    b0 = nbv; f0 = nfd;
    send_frame(8'h41);
    check("a_nbv",   32'(nbv - b0), 32'd1);
    check("a_data",  32'(data_log[b0 % 16]), 32'h41);
    check("a_idx",   32'(idx_log[b0 % 16]), 32'd0);
    check("a_nfd",   32'(nfd - f0), 32'd1);
    check("a_ok",    32'(last_ok), 32'd1);
    check("a_bytes", 32'(last_bytes), 32'd1);

    // low 95 is still a '1' -> 0x80
    b0 = nbv;
    send_bit(95, 97);
    for (int i = 0; i < 7; i++) send_bit(144, 48);
    send_bit(48, 0);
    idle(260);
    check("th95_data", 32'(data_log[b0 % 16]), 32'h80);
    check("th95_ok",   32'(last_ok), 32'd1);

    // low 96 is a '0' -> 0x00
    b0 = nbv;
    send_bit(96, 96);
    for (int i = 0; i < 7; i++) send_bit(144, 48);
    send_bit(48, 0);
    idle(260);
    check("th96_data", 32'(data_log[b0 % 16]), 32'h00);
    check("th96_nbv",  32'(nbv - b0), 32'd1);

    // line stuck low for 300 cycles
    f0 = nfd; s0 = nst; c0 = cyc;
    line = 1'b0;
    repeat (300) @(negedge clk);
    check("stuck_n",   32'(nst - s0), 32'd1);
    check("stuck_at",  32'(stuck_cyc - c0), 32'd240);
    check("stuck_nfd0", 32'(nfd - f0), 32'd0);
    idle(260);
    check("stuck_nfd", 32'(nfd - f0), 32'd1);
    check("stuck_ok",  32'(last_ok), 32'd0);
    check("stuck_fb",  32'(last_bytes), 32'd0);

    // nine 0xFF bytes: ninth is dropped and the frame is marked bad
    b0 = nbv; f0 = nfd;
    for (int k = 0; k < 9; k++) send_byte(8'hFF);
    send_bit(48, 0);
    idle(260);
    check("ovf_nbv",   32'(nbv - b0), 32'd8);
    check("ovf_idx0",  32'(idx_log[b0 % 16]), 32'd0);
    check("ovf_idx7",  32'(idx_log[(b0 + 7) % 16]), 32'd7);
    check("ovf_data7", 32'(data_log[(b0 + 7) % 16]), 32'hFF);
    check("ovf_nfd",   32'(nfd - f0), 32'd1);
    check("ovf_ok",    32'(last_ok), 32'd0);
    check("ovf_fb",    32'(last_bytes), 32'd8);

    // missing stop bit
    b0 = nbv; f0 = nfd;
    send_byte(8'h5A);
    idle(260);
    check("nostop_data", 32'(data_log[b0 % 16]), 32'h5A);
    check("nostop_nfd",  32'(nfd - f0), 32'd1);
    check("nostop_ok",   32'(last_ok), 32'd0);
    check("nostop_fb",   32'(last_bytes), 32'd1);

    // enable dropped mid-byte
    b0 = nbv; f0 = nfd; s0 = nst;
    send_bit(48, 144);
    send_bit(144, 48);
    send_bit(48, 144);
    line = 1'b0;
    repeat (20) @(negedge clk);
    enable = 1'b0;
    repeat (30) @(negedge clk);
    idle(10);
    enable = 1'b1;
    idle(300);
    check("en_nbv",   32'(nbv - b0), 32'd0);
    check("en_nfd",   32'(nfd - f0), 32'd0);
    check("en_stuck", 32'(nst - s0), 32'd0);
    check("en_hold",  32'(byte_data), 32'h5A);
    send_frame(8'h3C);
    check("en_data",  32'(data_log[b0 % 16]), 32'h3C);
    check("en_ok",    32'(last_ok), 32'd1);
    check("en_fb",    32'(last_bytes), 32'd1);

    // reset after 5 bits of a frame
    for (int i = 0; i < 5; i++) send_bit(48, 144);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mrst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    b0 = nbv; f0 = nfd;
    send_frame(8'hC3);
    check("mrst_nbv",  32'(nbv - b0), 32'd1);
    check("mrst_data", 32'(data_log[b0 % 16]), 32'hC3);
    check("mrst_idx",  32'(idx_log[b0 % 16]), 32'd0);
    check("mrst_nfd",  32'(nfd - f0), 32'd1);
    check("mrst_ok",   32'(last_ok), 32'd1);
    check("mrst_fb",   32'(last_bytes), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
